fir_mac_sequencer: RTL and testbench
====================================

FIR_MAC_SEQUENCER -- requirements
Module: fir_mac_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning signed sample and output width.
REQ-002 SHALL have parameter SHIFT, default 10, meaning the arithmetic right-shift applied to the accumulator before output.
REQ-003 clk_in  input  1  single system clock; all logic on its rising edge.
REQ-004 rst_in  input  1  reset; synchronous and active-high.
REQ-005 sample_in  input  WIDTH  signed audio sample.
REQ-006 sample_valid_in  input  1  sample_in is valid this cycle.
REQ-007 filtered_out  output  WIDTH  signed filtered sample; holds its value between results.
REQ-008 filtered_valid_out  output  1  one-cycle pulse when filtered_out updates.
REQ-009 busy_out  output  1  high while a computation is in progress.
REQ-010 overrun_out  output  1  one-cycle pulse when a sample is dropped.

Function
REQ-011 SHALL compute a 31-tap FIR, y = sum over k=0..30 of c[k]*x[n-k], using one time-shared multiply-accumulate unit.
REQ-012 Coefficients SHALL be the symmetric set c[0..15] = -1,-2,-2,0,5,10,10,0,-19,-37,-36,0,70,157,229,257 and c[16..30] = c[14..0].
REQ-013 Samples SHALL be stored in a 31-entry circular buffer with write pointer wr_ptr, which wraps from 30 to 0.
REQ-014 State machine SHALL have the states IDLE, ACCUM and DONE.
REQ-015 IDLE with sample_valid_in=1 (accept edge):
- write sample_in to buffer[wr_ptr];
- advance wr_ptr;
- clear the accumulator;
- set tap index k=0;
- go to ACCUM.
REQ-016 ACCUM: each edge SHALL add c[k]*buffer[(newest_ptr-k) mod 31] to the accumulator and increment k; after the k=30 edge, go to DONE.
REQ-017 DONE: one edge SHALL register the saturated (accumulator >>> SHIFT) into filtered_out, pulse filtered_valid_out, and go to IDLE.
REQ-018 Latency: filtered_valid_out SHALL be high in the 32nd cycle after the accept edge (TAPS+1 edges); throughput SHALL be one sample per 33 cycles maximum.
REQ-019 busy_out SHALL be high in ACCUM and DONE and low in IDLE.
REQ-020 sample_valid_in while busy_out=1 SHALL drop the sample, leave buffer and wr_ptr unchanged, and pulse overrun_out in the following cycle.
REQ-021 The accumulator SHALL be signed WIDTH+16 bits and use full-precision products with no intermediate truncation.
REQ-022 Output SHALL saturate to [-2^(WIDTH-1), 2^(WIDTH-1)-1] after the arithmetic shift; the shift floors toward negative infinity.
REQ-023 A sample arriving in the same cycle that DONE completes SHALL be treated as busy (dropped, overrun).

Reset
REQ-024 rst_in SHALL force:
- state IDLE;
- wr_ptr=0 and k=0;
- accumulator=0;
- all 31 buffer entries = 0;
- filtered_out=0;
- filtered_valid_out=0, busy_out=0, overrun_out=0.
REQ-025 Reset during ACCUM or DONE SHALL abort the computation with no filtered_valid_out pulse.
REQ-026 rst_in SHALL take priority over sample_valid_in in the same cycle.

Structure
REQ-027 Package fir_pkg SHALL hold:
- TAPS=31;
- the coefficient array;
- ACC_WIDTH rule (WIDTH+16);
- the state enum typedef.
REQ-028 Sub-module fir_mac SHALL hold the signed multiply, the accumulator register and the synchronous clear; the sequencer owns the buffer, pointers and FSM.

Verification
REQ-029 Impulse: single sample 127 after reset, then 30 samples of 0 each spaced 33 cycles:
- first output = (127*-1)>>>10 = -1;
- 16th output = (127*257)>>>10 = 31;
- all outputs match (127*c[k])>>>10.
REQ-030 Step: constant 127 for 40 samples -> from the 31st output onward filtered_out = 127 (127*1025 = 130175 >>> 10).
REQ-031 Saturation: constant -128 for 40 samples -> from the 31st output onward filtered_out = -128 (raw -129 clamped).
REQ-032 Overrun: second sample_valid_in 5 cycles after an accept -> overrun_out pulses once, only one filtered_valid_out, wr_ptr advances by 1.
REQ-033 Reset mid-ACCUM: assert rst_in at k=12 -> no valid pulse, busy_out=0 next cycle; a repeat of REQ-029 reproduces the same outputs.
REQ-034 Latency and wrap: 70 back-to-back accepted samples at 33-cycle spacing -> each valid exactly 32 cycles after its accept, results match a golden model across the wr_ptr wrap.

Source files
------------

// File: rtl/fir_pkg.sv
// Shared constants, coefficient table and FSM state type for the 31-tap FIR sequencer.
// The coefficients are a symmetric low-pass set whose taps sum to 1025 (unity gain after >>> 10).
package fir_pkg;

    localparam int TAPS      = 31;
    localparam int COEF_W    = 16;
    localparam int ACC_GUARD = 16;

    localparam logic signed [COEF_W-1:0] COEFS [TAPS] = '{
        -16'sd1,   -16'sd2,   -16'sd2,   16'sd0,    16'sd5,    16'sd10,   16'sd10,   16'sd0,
        -16'sd19,  -16'sd37,  -16'sd36,  16'sd0,    16'sd70,   16'sd157,  16'sd229,  16'sd257,
        16'sd229,  16'sd157,  16'sd70,   16'sd0,    -16'sd36,  -16'sd37,  -16'sd19,  16'sd0,
        16'sd10,   16'sd10,   16'sd5,    16'sd0,    -16'sd2,   -16'sd2,   -16'sd1
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } fir_state_t;

    // Accumulator width grows with the sample width by a fixed guard.
    function automatic int acc_width(input int width);
        return width + ACC_GUARD;
    endfunction

endpackage

// File: rtl/fir_mac.sv
// Time-shared signed multiply-accumulate: full-precision product added into a
// WIDTH+16 bit accumulator, with a synchronous clear that has priority over accumulate.
module fir_mac
    import fir_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    input  logic                          i_clear,
    input  logic                          i_en,
    input  logic [WIDTH-1:0]              i_sample,
    input  logic [COEF_W-1:0]             i_coef,
    output logic [WIDTH+ACC_GUARD-1:0]    o_acc
);

    localparam int ACC_W = acc_width(WIDTH);

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_product;

    // WIDTH x 16 signed product fits exactly in ACC_W bits, so nothing is truncated.
    assign w_product = ACC_W'($signed(i_sample)) * ACC_W'($signed(i_coef));

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= r_acc + w_product;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/fir_mac_sequencer.sv
// 31-tap FIR over a circular sample buffer, one MAC per cycle: accept, 31 accumulate
// edges, one output edge. Samples offered while busy are dropped and flagged.
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int SHIFT = 10
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [WIDTH-1:0] sample_in,
    input  logic             sample_valid_in,
    output logic [WIDTH-1:0] filtered_out,
    output logic             filtered_valid_out,
    output logic             busy_out,
    output logic             overrun_out,
    output logic [1:0]       state_out
);

    localparam int ACC_W = acc_width(WIDTH);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << (WIDTH-1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    fir_state_t              r_state;
    fir_state_t              w_next_state;
    logic [WIDTH-1:0]        r_buf [TAPS];
    logic [4:0]              r_wr_ptr;
    logic [4:0]              r_newest_ptr;
    logic [4:0]              r_k;
    logic [WIDTH-1:0]        r_filtered;
    logic                    r_filtered_valid;
    logic                    r_overrun;

    logic                    w_accept;
    logic [5:0]              w_rd_wrap;
    logic [4:0]              w_rd_idx;
    logic [COEF_W-1:0]       w_coef;
    logic [ACC_W-1:0]        w_acc;
    logic signed [ACC_W-1:0] w_shifted;
    logic [WIDTH-1:0]        w_sat;

    assign w_accept = (r_state == ST_IDLE) && sample_valid_in;

    // Tap k reads the sample k positions older than the newest one, modulo 31.
    assign w_rd_wrap = {1'b0, r_newest_ptr} + 6'(TAPS) - {1'b0, r_k};
    assign w_rd_idx  = (r_newest_ptr >= r_k) ? (r_newest_ptr - r_k) : w_rd_wrap[4:0];
    assign w_coef    = (r_k < 5'(TAPS)) ? COEFS[r_k] : '0;

    fir_mac #(.WIDTH(WIDTH)) u_mac (
        .i_clk    (clk_in),
        .i_rst    (rst_in),
        .i_clear  (w_accept),
        .i_en     (r_state == ST_ACCUM),
        .i_sample (r_buf[w_rd_idx]),
        .i_coef   (w_coef),
        .o_acc    (w_acc)
    );

    assign w_shifted = $signed(w_acc) >>> SHIFT;

    always_comb begin
        w_sat = w_shifted[WIDTH-1:0];
        if (w_shifted > SAT_MAX) begin
            w_sat = SAT_MAX[WIDTH-1:0];
        end else if (w_shifted < SAT_MIN) begin
            w_sat = SAT_MIN[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (sample_valid_in) w_next_state = ST_ACCUM;
            ST_ACCUM: if (r_k == 5'(TAPS-1)) w_next_state = ST_DONE;
            ST_DONE:  w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        busy_out  = (r_state != ST_IDLE);
        state_out = r_state;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < TAPS; i++) begin
                r_buf[i] <= '0;
            end
            r_wr_ptr         <= '0;
            r_newest_ptr     <= '0;
            r_k              <= '0;
            r_filtered       <= '0;
            r_filtered_valid <= 1'b0;
            r_overrun        <= 1'b0;
        end else begin
            r_filtered_valid <= 1'b0;
            // A sample arriving on the DONE edge is still treated as busy.
            r_overrun        <= sample_valid_in && (r_state != ST_IDLE);
            if (w_accept) begin
                r_buf[r_wr_ptr] <= sample_in;
                r_newest_ptr    <= r_wr_ptr;
                r_wr_ptr        <= (r_wr_ptr == 5'(TAPS-1)) ? '0 : r_wr_ptr + 5'd1;
                r_k             <= '0;
            end else if (r_state == ST_ACCUM) begin
                r_k <= r_k + 5'd1;
            end
            if (r_state == ST_DONE) begin
                r_filtered       <= w_sat;
                r_filtered_valid <= 1'b1;
            end
        end
    end

    assign filtered_out       = r_filtered;
    assign filtered_valid_out = r_filtered_valid;
    assign overrun_out        = r_overrun;

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Scenario bench for fir_mac_sequencer: a direct-form FIR model over a sample history
// feeds an expected queue that a negedge monitor drains on every filtered_valid_out.
module tb_fir_mac_sequencer;

    localparam int WIDTH = 8;
    localparam int SHIFT = 10;
    localparam int TAPS  = 31;

    logic             clk_in = 1'b0;
    logic             rst_in;
    logic [WIDTH-1:0] sample_in;
    logic             sample_valid_in;
    logic [WIDTH-1:0] filtered_out;
    logic             filtered_valid_out;
    logic             busy_out;
    logic             overrun_out;
    logic [1:0]       state_out;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int valid_cnt = 0;
    int ovr_cnt   = 0;

    logic [WIDTH-1:0] exp_q[$];
    int               exp_cyc_q[$];
    logic [WIDTH-1:0] got_q[$];
    logic [WIDTH-1:0] imp_ref[$];
    logic [WIDTH-1:0] mon_exp;
    int               mon_cyc;

    int c_half[16] = '{-1, -2, -2, 0, 5, 10, 10, 0, -19, -37, -36, 0, 70, 157, 229, 257};
    int coef[TAPS];
    int hist[TAPS];

    fir_mac_sequencer #(.WIDTH(WIDTH), .SHIFT(SHIFT)) dut (
        .clk_in             (clk_in),
        .rst_in             (rst_in),
        .sample_in          (sample_in),
        .sample_valid_in    (sample_valid_in),
        .filtered_out       (filtered_out),
        .filtered_valid_out (filtered_valid_out),
        .busy_out           (busy_out),
        .overrun_out        (overrun_out),
        .state_out          (state_out)
    );

    always #5 clk_in = ~clk_in;

    always @(posedge clk_in) cyc <= cyc + 1;

    always @(negedge clk_in) begin
        if (filtered_valid_out === 1'b1) begin
            valid_cnt++;
            got_q.push_back(filtered_out);
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid got=%0d required=no_output cyc=%0d", $signed(filtered_out), cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                mon_cyc = exp_cyc_q.pop_front();
                if (filtered_out !== mon_exp) begin
                    failures++;
                    $display("FAIL filtered_value got=%0d required=%0d cyc=%0d", $signed(filtered_out), $signed(mon_exp), cyc);
                end
                checks++;
                if (cyc !== mon_cyc) begin
                    failures++;
                    $display("FAIL valid_latency got_cyc=%0d required_cyc=%0d", cyc, mon_cyc);
                end
            end
        end
        if (overrun_out === 1'b1) ovr_cnt++;
    end

    task automatic model_clear();
        for (int i = 0; i < TAPS; i++) hist[i] = 0;
        exp_q.delete();
        exp_cyc_q.delete();
        got_q.delete();
    endtask

    task automatic model_accept(input logic [WIDTH-1:0] s);
        longint acc;
        longint y;
        for (int i = TAPS - 1; i > 0; i--) hist[i] = hist[i-1];
        hist[0] = int'($signed(s));
        acc = 0;
        for (int k = 0; k < TAPS; k++) acc += longint'(coef[k]) * longint'(hist[k]);
        y = acc >>> SHIFT;
        if (y > 127) y = 127;
        else if (y < -128) y = -128;
        exp_q.push_back(WIDTH'(y));
        exp_cyc_q.push_back(cyc + 32);
    endtask

    task automatic reset_dut();
        @(negedge clk_in);
        rst_in          = 1'b1;
        sample_valid_in = 1'b0;
        repeat (3) @(negedge clk_in);
        rst_in = 1'b0;
        model_clear();
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge after the accept edge.
    task automatic send_sample(input logic [WIDTH-1:0] s);
        sample_in       = s;
        sample_valid_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        sample_valid_in = 1'b0;
        model_accept(s);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy_out !== 1'b0 && n < 100) begin
            @(negedge clk_in);
            n++;
        end
        if (busy_out !== 1'b0) begin
            checks++;
            failures++;
            $display("FAIL %s_idle_timeout busy_out=%b required=0", name, busy_out);
        end
    endtask

    task automatic drain(input string name);
        wait_idle(name);
        repeat (2) @(negedge clk_in);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain pending=%0d required=0", name, exp_q.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk_in);
        rst_in          = 1'b1;
        sample_valid_in = 1'b1;
        sample_in       = 8'd55;
        repeat (3) @(negedge clk_in);
        checks++;
        if ({filtered_out, filtered_valid_out, busy_out, overrun_out, state_out} !== 13'd0) begin
            failures++;
            $display("FAIL reset_outputs got=%h required=0", {filtered_out, filtered_valid_out, busy_out, overrun_out, state_out});
        end
        rst_in          = 1'b0;
        sample_valid_in = 1'b0;
        @(negedge clk_in);
        checks++;
        if (busy_out !== 1'b0 || overrun_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_priority busy=%b overrun=%b required=0/0", busy_out, overrun_out);
        end
        model_clear();
    endtask

    task automatic test_impulse(input bit save_ref);
        reset_dut();
        send_sample(8'sd127);
        for (int i = 0; i < 30; i++) begin
            wait_idle("impulse");
            send_sample(8'd0);
        end
        drain("impulse");
        checks++;
        if (got_q.size() != 31) begin
            failures++;
            $display("FAIL impulse_count got=%0d required=31", got_q.size());
        end else begin
            checks++;
            if (got_q[0] !== 8'hFF) begin
                failures++;
                $display("FAIL impulse_first got=%0d required=-1", $signed(got_q[0]));
            end
            checks++;
            if (got_q[15] !== 8'd31) begin
                failures++;
                $display("FAIL impulse_peak got=%0d required=31", $signed(got_q[15]));
            end
            if (save_ref) begin
                imp_ref = got_q;
            end else begin
                for (int i = 0; i < 31; i++) begin
                    checks++;
                    if (got_q[i] !== imp_ref[i]) begin
                        failures++;
                        $display("FAIL impulse_repeat idx=%0d got=%0d required=%0d", i, $signed(got_q[i]), $signed(imp_ref[i]));
                    end
                end
            end
        end
    endtask

    task automatic test_constant(input string name, input logic [WIDTH-1:0] s, input logic [WIDTH-1:0] settled);
        reset_dut();
        for (int i = 0; i < 40; i++) begin
            send_sample(s);
            wait_idle(name);
        end
        drain(name);
        checks++;
        if (got_q.size() != 40) begin
            failures++;
            $display("FAIL %s_count got=%0d required=40", name, got_q.size());
        end else begin
            for (int i = 30; i < 40; i++) begin
                checks++;
                if (got_q[i] !== settled) begin
                    failures++;
                    $display("FAIL %s_settled idx=%0d got=%0d required=%0d", name, i, $signed(got_q[i]), $signed(settled));
                end
            end
        end
    endtask

    task automatic test_overrun();
        int ovr0;
        int val0;
        reset_dut();
        ovr0 = ovr_cnt;
        val0 = valid_cnt;
        send_sample(8'd40);
        repeat (4) @(negedge clk_in);
        sample_in       = 8'd99;
        sample_valid_in = 1'b1;
        @(negedge clk_in);
        sample_valid_in = 1'b0;
        checks++;
        if (overrun_out !== 1'b1) begin
            failures++;
            $display("FAIL overrun_pulse got=%b required=1", overrun_out);
        end
        wait_idle("overrun");
        send_sample(8'd20);
        repeat (31) @(negedge clk_in);
        sample_in       = 8'd77;
        sample_valid_in = 1'b1;
        @(negedge clk_in);
        sample_valid_in = 1'b0;
        checks++;
        if (overrun_out !== 1'b1 || busy_out !== 1'b0) begin
            failures++;
            $display("FAIL overrun_done_edge overrun=%b busy=%b required=1/0", overrun_out, busy_out);
        end
        wait_idle("overrun");
        send_sample(8'd30);
        drain("overrun");
        checks++;
        if (ovr_cnt - ovr0 != 2) begin
            failures++;
            $display("FAIL overrun_count got=%0d required=2", ovr_cnt - ovr0);
        end
        checks++;
        if (valid_cnt - val0 != 3) begin
            failures++;
            $display("FAIL overrun_valid_count got=%0d required=3", valid_cnt - val0);
        end
    endtask

    task automatic test_reset_mid_accum();
        int val0;
        reset_dut();
        val0            = valid_cnt;
        sample_in       = 8'sd127;
        sample_valid_in = 1'b1;
        @(posedge clk_in);
        @(negedge clk_in);
        sample_valid_in = 1'b0;
        repeat (12) @(negedge clk_in);
        checks++;
        if (state_out !== 2'd1) begin
            failures++;
            $display("FAIL abort_in_accum state=%0d required=1", state_out);
        end
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        checks++;
        if (busy_out !== 1'b0) begin
            failures++;
            $display("FAIL abort_busy got=%b required=0", busy_out);
        end
        repeat (40) @(negedge clk_in);
        checks++;
        if (valid_cnt != val0) begin
            failures++;
            $display("FAIL abort_no_valid got=%0d required=0", valid_cnt - val0);
        end
        test_impulse(1'b0);
    endtask

    task automatic test_back_to_back();
        reset_dut();
        for (int i = 0; i < 70; i++) begin
            send_sample(WIDTH'($urandom_range(0, 255)));
            wait_idle("b2b");
        end
        drain("b2b");
        checks++;
        if (got_q.size() != 70) begin
            failures++;
            $display("FAIL b2b_count got=%0d required=70", got_q.size());
        end
    endtask

    initial begin
        rst_in          = 1'b1;
        sample_valid_in = 1'b0;
        sample_in       = '0;
        for (int i = 0; i < 16; i++) coef[i] = c_half[i];
        for (int i = 16; i < TAPS; i++) coef[i] = c_half[30 - i];
        model_clear();

        test_reset();
        test_impulse(1'b1);
        test_constant("step", 8'sd127, 8'sd127);
        test_constant("saturation", 8'h80, 8'h80);
        test_overrun();
        test_reset_mid_accum();
        test_back_to_back();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
